regfile_mp: RTL and testbench

- Parametrised multi-port integer register file for the OSYRYS-64 core and its NPU.
- Generalises the single-core regfile in four ways: configurable width, depth and read/write port count; per-register outstanding-write counters instead of a single pending bit; an issue handshake; and a flush.
- Sits between decode/issue (reads, issue reservations) and the writeback stage and NPU (write ports). The hazard unit consumes the pending and busy outputs.

---
 rtl/regfile_mp_pkg.sv | 23 ++
 rtl/regfile_mp_sbcnt.sv | 44 ++++
 rtl/regfile_mp.sv | 138 +++++++++++++
 tb/tb_regfile_mp.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared types and helpers for the regfile_mp multi-port register file.
// Optional write-through bypass is enabled by defining REGFILE_MP_BYPASS_EN.
package regfile_mp_pkg;

  localparam int NREGS_DEF = 32;

  // Address width for a register file of nregs entries (never narrower than 1 bit).
  function automatic int aw_of(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  localparam int AW = aw_of(NREGS_DEF);

  typedef logic [AW-1:0] reg_addr_t;

  localparam int ZERO_REG = 0;

  // Low bit of element `port` inside a packed bus of `width`-bit elements.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_mp_sbcnt.sv
// Per-register outstanding-write counter: saturating up/down counter with flush.
// It clamps to 0 on under-run and holds at full.
module regfile_mp_sbcnt
  import regfile_mp_pkg::*;
#(
  parameter int CNTW = 2,
  parameter int DW   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc_i,
  input  logic [DW-1:0]   dec_i,
  input  logic            flush_i,
  output logic [CNTW-1:0] cnt_o,
  output logic            full_o,
  output logic            nonzero_o
);

  localparam int MAX = (1 << CNTW) - 1;

  logic [CNTW-1:0] cnt_q, cnt_d;
  int              net;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    net   = int'(cnt_q) + int'(inc_i) - int'(dec_i);
    cnt_d = cnt_q;
    if (flush_i)         cnt_d = '0;
    else if (net <= 0)   cnt_d = '0;
    else if (net >= MAX) cnt_d = CNTW'(MAX);
    else                 cnt_d = CNTW'(net);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o     = cnt_q;
  assign full_o    = (cnt_q == CNTW'(MAX));
  assign nonzero_o = (cnt_q != '0);

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with per-register outstanding-write counters,
// issue handshake and flush. Define REGFILE_MP_BYPASS_EN for write-through reads.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter  int XLEN   = 64,
  parameter  int NREGS  = 32,
  parameter  int NRD    = 4,
  parameter  int NWR    = 2,
  parameter  int CNTW   = 2,
  localparam int ADDR_W = aw_of(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*XLEN-1:0]   rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic [NWR*XLEN-1:0]   wr_data,
  input  logic [NWR-1:0]        wr_retire,
  input  logic                  iss_valid,
  input  logic [ADDR_W-1:0]     iss_addr,
  output logic                  iss_ready,
  input  logic                  flush,
  output logic [NREGS-1:0]      pending
);

  localparam int DW = $clog2(NWR + 1);

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [XLEN-1:0]   word_t;

  addr_t rd_a [NRD];
  addr_t wr_a [NWR];
  word_t wr_d [NWR];

  for (genvar i = 0; i < NRD; i++) begin : g_rd_unpack
    assign rd_a[i] = rd_addr[slice_lo(i, ADDR_W) +: ADDR_W];
  end

  for (genvar p = 0; p < NWR; p++) begin : g_wr_unpack
    assign wr_a[p] = wr_addr[slice_lo(p, ADDR_W) +: ADDR_W];
    assign wr_d[p] = wr_data[slice_lo(p, XLEN) +: XLEN];
  end

  // Register storage. Entry 0 is kept at zero so reads need no special case.
  word_t mem_q [NREGS];
  word_t mem_d [NREGS];

  always_comb begin
    mem_d = mem_q;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p] && (wr_a[p] != addr_t'(ZERO_REG))) mem_d[wr_a[p]] = wr_d[p];
    end
    mem_d[ZERO_REG] = '0;
  end

  // NOTE: the array is reset because architectural state must read as zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) mem_q[r] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Outstanding-write bookkeeping.
  logic [NREGS-1:0] inc;
  logic [NREGS-1:0] full;
  logic [NREGS-1:0] nonzero;
  logic [DW-1:0]    dec [NREGS];
  logic [CNTW-1:0]  cnt [NREGS];

  assign iss_ready = !flush && ((iss_addr == addr_t'(ZERO_REG)) || !full[iss_addr]);

  always_comb begin
    inc = '0;
    if (iss_valid && iss_ready) inc[iss_addr] = 1'b1;
  end

  always_comb begin
    for (int r = 0; r < NREGS; r++) dec[r] = '0;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p] && wr_retire[p]) dec[wr_a[p]] = dec[wr_a[p]] + DW'(1);
    end
  end

  assign full[ZERO_REG]    = 1'b0;
  assign nonzero[ZERO_REG] = 1'b0;
  assign cnt[ZERO_REG]     = '0;

  for (genvar r = 1; r < NREGS; r++) begin : g_cnt
    regfile_mp_sbcnt #(
      .CNTW (CNTW),
      .DW   (DW)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc_i     (inc[r]),
      .dec_i     (dec[r]),
      .flush_i   (flush),
      .cnt_o     (cnt[r]),
      .full_o    (full[r]),
      .nonzero_o (nonzero[r])
    );
  end

  assign pending = nonzero;

  // Read ports; with bypass the highest-index matching write port wins.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_data[i*XLEN +: XLEN] = mem_q[rd_a[i]];
      rd_busy[i]              = nonzero[rd_a[i]];
`ifdef REGFILE_MP_BYPASS_EN
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] && (wr_a[p] != addr_t'(ZERO_REG)) && (wr_a[p] == rd_a[i])) begin
          rd_data[i*XLEN +: XLEN] = wr_d[p];
          if (wr_retire[p] && (cnt[rd_a[i]] == CNTW'(1))) rd_busy[i] = 1'b0;
        end
      end
`endif
    end
  end

  // Slot-0 bookkeeping (and the counts when bypass is off) feed no logic.
  logic unused_sink;
  always_comb begin
    unused_sink = inc[ZERO_REG] ^ (^dec[ZERO_REG]);
`ifndef REGFILE_MP_BYPASS_EN
    for (int r = 0; r < NREGS; r++) unused_sink = unused_sink ^ (^cnt[r]);
`endif
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic
// compared every cycle against an array-based reference model.
module tb_regfile_mp;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int NRD   = 4;
  localparam int NWR   = 2;
  localparam int AWB   = 5;
  localparam int CMAX  = 3;

  logic                 clk;
  logic                 rst;
  logic [NRD*AWB-1:0]   rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_busy;
  logic [NWR-1:0]       wr_en;
  logic [NWR*AWB-1:0]   wr_addr;
  logic [NWR*XLEN-1:0]  wr_data;
  logic [NWR-1:0]       wr_retire;
  logic                 iss_valid;
  logic [AWB-1:0]       iss_addr;
  logic                 iss_ready;
  logic                 flush;
  logic [NREGS-1:0]     pending;

  regfile_mp #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR),
    .CNTW  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_retire (wr_retire),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .flush     (flush),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%h expected=0x%h", tag, got, exp);
    end
  endtask

  // Reference model: architectural values and outstanding-write counts.
  logic [63:0] m_regs [NREGS];
  int          m_cnt  [NREGS];

  function automatic void model_reset();
    for (int r = 0; r < NREGS; r++) begin
      m_regs[r] = '0;
      m_cnt[r]  = 0;
    end
  endfunction

  function automatic logic model_ready();
    if (flush) return 1'b0;
    if (iss_addr == 0) return 1'b1;
    return m_cnt[iss_addr] != CMAX;
  endfunction

  task automatic set_idle();
    rd_addr   = '0;
    wr_en     = '0;
    wr_addr   = '0;
    wr_data   = '0;
    wr_retire = '0;
    iss_valid = 1'b0;
    iss_addr  = '0;
    flush     = 1'b0;
  endtask

  task automatic set_rd(input int port, input int addr);
    rd_addr[port*AWB +: AWB] = AWB'(addr);
  endtask

  task automatic set_wr(input int port, input int addr, input logic [63:0] data, input logic retire);
    wr_en[port]               = 1'b1;
    wr_addr[port*AWB +: AWB]  = AWB'(addr);
    wr_data[port*XLEN +: XLEN] = data;
    wr_retire[port]           = retire;
  endtask

  task automatic set_iss(input int addr);
    iss_valid = 1'b1;
    iss_addr  = AWB'(addr);
  endtask

  // Let combinational outputs settle mid-cycle and compare them with the model.
  task automatic sample();
    logic [63:0]      exp_d;
    logic [NRD-1:0]   exp_busy;
    logic [NREGS-1:0] exp_pend;
    int               a;
    int               wa;
    #2;
    exp_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      a           = int'(rd_addr[i*AWB +: AWB]);
      exp_d       = (a == 0) ? 64'd0 : m_regs[a];
      exp_busy[i] = (m_cnt[a] != 0);
`ifdef REGFILE_MP_BYPASS_EN
      for (int p = 0; p < NWR; p++) begin
        wa = int'(wr_addr[p*AWB +: AWB]);
        if (wr_en[p] && wa != 0 && wa == a) begin
          exp_d = wr_data[p*XLEN +: XLEN];
          if (wr_retire[p] && m_cnt[a] == 1) exp_busy[i] = 1'b0;
        end
      end
`else
      wa = 0;
`endif
      check($sformatf("rd_data[%0d] x%0d", i, a), rd_data[i*XLEN +: XLEN], exp_d);
    end
    for (int r = 0; r < NREGS; r++) exp_pend[r] = (m_cnt[r] != 0);
    check("rd_busy", 64'(rd_busy), 64'(exp_busy));
    check("iss_ready", 64'(iss_ready), 64'(model_ready()));
    check("pending", 64'(pending), 64'(exp_pend));
  endtask

  // Clock edge, then apply the architectural rules to the model.
  task automatic advance();
    logic accept;
    int   wa;
    int   net;
    int   dec [NREGS];
    accept = iss_valid && model_ready();
    @(posedge clk);
    for (int r = 0; r < NREGS; r++) dec[r] = 0;
    for (int p = 0; p < NWR; p++) begin
      wa = int'(wr_addr[p*AWB +: AWB]);
      if (wr_en[p] && wa != 0) begin
        m_regs[wa] = wr_data[p*XLEN +: XLEN];
        if (wr_retire[p]) dec[wa]++;
      end
    end
    for (int r = 1; r < NREGS; r++) begin
      if (flush) begin
        m_cnt[r] = 0;
      end else begin
        net = m_cnt[r] + ((accept && int'(iss_addr) == r) ? 1 : 0) - dec[r];
        m_cnt[r] = (net < 0) ? 0 : (net > CMAX) ? CMAX : net;
      end
    end
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  initial begin
    set_idle();
    model_reset();
    rst = 1'b1;
    #3;
    check("reset_pending", 64'(pending), 64'd0);
    check("reset_busy", 64'(rd_busy), 64'd0);
    #9 rst = 1'b0;
    @(posedge clk);
    #1;

    // All registers on all ports read zero after reset.
    for (int k = 0; k < NREGS / NRD; k++) begin
      set_idle();
      for (int i = 0; i < NRD; i++) set_rd(i, k * NRD + i);
      sample();
      check("reset_iss_ready", 64'(iss_ready), 64'd1);
      advance();
    end

    // x5 write then read on port 3; write to x0 is dropped.
    set_idle();
    set_wr(0, 5, 64'hDEAD_BEEF_0000_0001, 1'b0);
    step();
    set_idle();
    set_rd(3, 5);
    set_wr(0, 0, 64'hFF, 1'b1);
    sample();
    check("x5_read", rd_data[3*XLEN +: XLEN], 64'hDEAD_BEEF_0000_0001);
    advance();
    set_idle();
    set_rd(0, 0);
    sample();
    check("x0_read", rd_data[0 +: XLEN], 64'd0);
    advance();

    // Same-address dual write, then double issue and double retire.
    set_idle();
    set_wr(0, 7, 64'h11, 1'b0);
    set_wr(1, 7, 64'h22, 1'b0);
    step();
    set_idle();
    set_rd(2, 7);
    set_iss(7);
    sample();
    check("x7_high_port_wins", rd_data[2*XLEN +: XLEN], 64'h22);
    advance();
    set_idle();
    set_iss(7);
    step();
    set_idle();
    sample();
    check("x7_pending_cnt2", 64'(pending[7]), 64'd1);
    advance();
    set_idle();
    set_wr(0, 7, 64'h33, 1'b1);
    set_wr(1, 7, 64'h44, 1'b1);
    step();
    set_idle();
    sample();
    check("x7_pending_cleared", 64'(pending[7]), 64'd0);
    advance();

    // Counter saturation and issue stall on x3.
    for (int k = 0; k < 3; k++) begin
      set_idle();
      set_iss(3);
      step();
    end
    set_idle();
    set_iss(3);
    sample();
    check("x3_stall_at_max", 64'(iss_ready), 64'd0);
    advance();
    set_wr(0, 3, 64'h3, 1'b1);
    sample();
    check("x3_no_lookahead", 64'(iss_ready), 64'd0);
    advance();
    set_idle();
    set_iss(3);
    sample();
    check("x3_ready_after_retire", 64'(iss_ready), 64'd1);
    advance();

    // Simultaneous issue and retire nets out; flush clears everything.
    set_idle();
    set_iss(9);
    step();
    set_iss(9);
    set_wr(0, 9, 64'h99, 1'b1);
    step();
    set_idle();
    sample();
    check("x9_net_zero", 64'(pending[9]), 64'd1);
    advance();
    set_idle();
    flush = 1'b1;
    set_iss(9);
    sample();
    check("flush_blocks_issue", 64'(iss_ready), 64'd0);
    advance();
    set_idle();
    sample();
    check("flush_clears_pending", 64'(pending), 64'd0);
    advance();

    // Write-through behaviour on x12.
    set_idle();
    set_wr(0, 12, 64'h55, 1'b0);
    set_iss(12);
    step();
    set_idle();
    set_wr(1, 12, 64'h1234, 1'b1);
    set_rd(0, 12);
    sample();
`ifdef REGFILE_MP_BYPASS_EN
    check("x12_bypass_data", rd_data[0 +: XLEN], 64'h1234);
    check("x12_bypass_busy", 64'(rd_busy[0]), 64'd0);
`else
    check("x12_stored_data", rd_data[0 +: XLEN], 64'h55);
    check("x12_busy", 64'(rd_busy[0]), 64'd1);
`endif
    advance();

    // Randomized traffic, addresses confined to a few registers to force collisions.
    for (int n = 0; n < 600; n++) begin
      set_idle();
      for (int i = 0; i < NRD; i++) set_rd(i, $urandom_range(0, 7));
      for (int p = 0; p < NWR; p++) begin
        if ($urandom_range(0, 2) != 0)
          set_wr(p, $urandom_range(0, 7), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 3) != 0) set_iss($urandom_range(0, 7));
      flush = ($urandom_range(0, 24) == 0);
      step();
    end

    // Asynchronous reset mid-cycle: clears at once and drops the in-flight write.
    set_idle();
    for (int i = 0; i < NRD; i++) set_rd(i, i + 1);
    set_wr(0, 2, 64'hABCD, 1'b1);
    set_iss(4);
    rst = 1'b1;
    #1;
    check("async_rst_pending", 64'(pending), 64'd0);
    check("async_rst_rd1", rd_data[0 +: XLEN], 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    set_idle();
    set_rd(0, 2);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
